dmem_arbiter: RTL and testbench

- Shares the single data-memory/IO port behind the LSU between two requesters: port 0 is the core load/store path and port 1 is a debug/DMA loader.
- Round-robin arbitration with a req/gnt handshake. One transaction is in flight at a time.
- Read data returns after a fixed memory latency.
- Generates the core stall that freezes PC and regfile write while port 0 waits.

---
 rtl/dmem_arbiter.sv | 147 ++++++++++++++
 tb/tb_dmem_arbiter.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one data-memory port between the core (m0) and a debug/DMA loader (m1).
// Optional `ARB_LOCK_EN adds i_m1_lock so port 1 can hold the memory across several grants.
module dmem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int RD_LAT = 2
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_m0_req,
    input  logic              i_m0_we,
    input  logic [ADDR_W-1:0] i_m0_addr,
    input  logic [DATA_W-1:0] i_m0_wdata,
    input  logic [3:0]        i_m0_be,
    output logic              o_m0_gnt,
    output logic              o_m0_rvalid,
    output logic [DATA_W-1:0] o_m0_rdata,
    input  logic              i_m1_req,
    input  logic              i_m1_we,
    input  logic [ADDR_W-1:0] i_m1_addr,
    input  logic [DATA_W-1:0] i_m1_wdata,
    input  logic [3:0]        i_m1_be,
`ifdef ARB_LOCK_EN
    input  logic              i_m1_lock,
`endif
    output logic              o_m1_gnt,
    output logic              o_m1_rvalid,
    output logic [DATA_W-1:0] o_m1_rdata,
    output logic              o_mem_en,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    output logic [3:0]        o_mem_be,
    input  logic [DATA_W-1:0] i_mem_rdata,
    output logic              o_core_stall
);

    localparam logic [1:0] CNT_INIT = 2'(RD_LAT - 1);

    typedef enum logic {IDLE, RD_WAIT} state_t;

    state_t            state_q, state_d;
    logic [1:0]        cnt_q, cnt_d;
    logic              owner_q, owner_d;
    logic              rr_q, rr_d;
    logic              lock_q, lock_d;
    logic [DATA_W-1:0] rdata0_q, rdata1_q;

    logic rd_done, arb_free, lock_blk, gnt0, gnt1, rd_grant, rvalid0, rvalid1;

    // The rvalid cycle doubles as an IDLE cycle so reads can issue back-to-back.
    assign rd_done  = (state_q == RD_WAIT) && (cnt_q == 2'd0);
    assign arb_free = i_reset && ((state_q == IDLE) || rd_done);
    assign lock_blk = lock_q;

    assign gnt0     = arb_free & i_m0_req & ~lock_blk & (~i_m1_req | ~rr_q);
    assign gnt1     = arb_free & i_m1_req & (~i_m0_req | rr_q | lock_blk);
    assign rd_grant = (gnt0 & ~i_m0_we) | (gnt1 & ~i_m1_we);

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q  <= IDLE;
            cnt_q    <= 2'd0;
            owner_q  <= 1'b0;
            rr_q     <= 1'b0;
            lock_q   <= 1'b0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            owner_q <= owner_d;
            rr_q    <= rr_d;
            lock_q  <= lock_d;
            if (rvalid0) rdata0_q <= i_mem_rdata;
            if (rvalid1) rdata1_q <= i_mem_rdata;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        owner_d = owner_q;
        rr_d    = rr_q;
        lock_d  = lock_q;
        case (state_q)
            IDLE: begin
                if (rd_grant) begin
                    state_d = RD_WAIT;
                    cnt_d   = CNT_INIT;
                    owner_d = gnt1;
                end
            end
            RD_WAIT: begin
                if (cnt_q != 2'd0) begin
                    cnt_d = cnt_q - 2'd1;
                end else if (rd_grant) begin
                    cnt_d   = CNT_INIT;
                    owner_d = gnt1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // Pointer moves to the loser of each grant, contended or not.
        if (gnt0)      rr_d = 1'b1;
        else if (gnt1) rr_d = 1'b0;
`ifdef ARB_LOCK_EN
        if (gnt1) lock_d = i_m1_lock;
`else
        lock_d = 1'b0;
`endif
    end

    always_comb begin
        o_m0_gnt    = gnt0;
        o_m1_gnt    = gnt1;
        rvalid0     = rd_done & ~owner_q;
        rvalid1     = rd_done & owner_q;
        o_m0_rvalid = rvalid0;
        o_m1_rvalid = rvalid1;
        o_m0_rdata  = rvalid0 ? i_mem_rdata : rdata0_q;
        o_m1_rdata  = rvalid1 ? i_mem_rdata : rdata1_q;
        o_mem_en    = gnt0 | gnt1;
        o_mem_we    = 1'b0;
        o_mem_addr  = '0;
        o_mem_wdata = '0;
        o_mem_be    = 4'd0;
        if (gnt0) begin
            o_mem_we    = i_m0_we;
            o_mem_addr  = i_m0_addr;
            o_mem_wdata = i_m0_wdata;
            o_mem_be    = i_m0_be;
        end else if (gnt1) begin
            o_mem_we    = i_m1_we;
            o_mem_addr  = i_m1_addr;
            o_mem_wdata = i_m1_wdata;
            o_mem_be    = i_m1_be;
        end
        // Stall covers a waiting request plus a port 0 read from its gnt cycle up to (not including) rvalid.
        o_core_stall = (i_reset & i_m0_req & ~gnt0)
                     | (gnt0 & ~i_m0_we)
                     | ((state_q == RD_WAIT) & ~owner_q & ~rd_done);
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with RD_LAT=2; expectations switch on `ARB_LOCK_EN.
module tb_dmem_arbiter;
    logic        i_clk = 1'b0;
    logic        i_reset;
    logic        i_m0_req, i_m0_we, i_m1_req, i_m1_we;
    logic [31:0] i_m0_addr, i_m0_wdata, i_m1_addr, i_m1_wdata, i_mem_rdata;
    logic [3:0]  i_m0_be, i_m1_be;
    logic        o_m0_gnt, o_m0_rvalid, o_m1_gnt, o_m1_rvalid;
    logic [31:0] o_m0_rdata, o_m1_rdata, o_mem_addr, o_mem_wdata;
    logic        o_mem_en, o_mem_we, o_core_stall;
    logic [3:0]  o_mem_be;
`ifdef ARB_LOCK_EN
    logic        i_m1_lock;
`endif

    int errs = 0;
    int checks = 0;

    always #5 i_clk = ~i_clk;

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LAT(2)) dut (
        .i_clk(i_clk), .i_reset(i_reset),
        .i_m0_req(i_m0_req), .i_m0_we(i_m0_we), .i_m0_addr(i_m0_addr),
        .i_m0_wdata(i_m0_wdata), .i_m0_be(i_m0_be),
        .o_m0_gnt(o_m0_gnt), .o_m0_rvalid(o_m0_rvalid), .o_m0_rdata(o_m0_rdata),
        .i_m1_req(i_m1_req), .i_m1_we(i_m1_we), .i_m1_addr(i_m1_addr),
        .i_m1_wdata(i_m1_wdata), .i_m1_be(i_m1_be),
`ifdef ARB_LOCK_EN
        .i_m1_lock(i_m1_lock),
`endif
        .o_m1_gnt(o_m1_gnt), .o_m1_rvalid(o_m1_rvalid), .o_m1_rdata(o_m1_rdata),
        .o_mem_en(o_mem_en), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
        .o_mem_wdata(o_mem_wdata), .o_mem_be(o_mem_be),
        .i_mem_rdata(i_mem_rdata), .o_core_stall(o_core_stall)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $display("FAIL %s: observed=%h expected=%h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    // Inputs change just after the falling edge; checks run 1 time unit later.
    task automatic step();
        @(negedge i_clk);
    endtask

    initial begin
        i_reset = 1'b0;
        i_m0_req = 1'b1; i_m0_we = 1'b1; i_m0_addr = 32'h10; i_m0_wdata = 32'hA0; i_m0_be = 4'hF;
        i_m1_req = 1'b1; i_m1_we = 1'b1; i_m1_addr = 32'h20; i_m1_wdata = 32'hB0; i_m1_be = 4'h3;
        i_mem_rdata = 32'h0;
`ifdef ARB_LOCK_EN
        i_m1_lock = 1'b0;
`endif
        #3;
        chk("rst_gnt0", 32'(o_m0_gnt), 32'd0);
        chk("rst_gnt1", 32'(o_m1_gnt), 32'd0);
        chk("rst_en", 32'(o_mem_en), 32'd0);
        chk("rst_stall", 32'(o_core_stall), 32'd0);
        chk("rst_rv0", 32'(o_m0_rvalid), 32'd0);
        chk("rst_addr", o_mem_addr, 32'h0);
        chk("rst_rdata0", o_m0_rdata, 32'h0);

        // Release with both writing: strict alternation m0,m1,m0,m1
        step(); i_reset = 1'b1; #1;
        chk("alt0_gnt0", 32'(o_m0_gnt), 32'd1);
        chk("alt0_addr", o_mem_addr, 32'h10);
        chk("alt0_be", 32'(o_mem_be), 32'hF);
        step(); #1;
        chk("alt1_gnt1", 32'(o_m1_gnt), 32'd1);
        chk("alt1_gnt0", 32'(o_m0_gnt), 32'd0);
        chk("alt1_addr", o_mem_addr, 32'h20);
        chk("alt1_stall", 32'(o_core_stall), 32'd1);
        step(); #1;
        chk("alt2_gnt0", 32'(o_m0_gnt), 32'd1);
        chk("alt2_addr", o_mem_addr, 32'h10);
        step(); #1;
        chk("alt3_gnt1", 32'(o_m1_gnt), 32'd1);
        chk("alt3_wdata", o_mem_wdata, 32'hB0);

        step(); i_m0_req = 1'b0; i_m1_req = 1'b0; #1;
        chk("idle_en", 32'(o_mem_en), 32'd0);

        // Port 0 read of 0x100, data at T+2
        step(); i_m0_req = 1'b1; i_m0_we = 1'b0; i_m0_addr = 32'h100; #1;
        chk("rd_T_gnt0", 32'(o_m0_gnt), 32'd1);
        chk("rd_T_we", 32'(o_mem_we), 32'd0);
        chk("rd_T_addr", o_mem_addr, 32'h100);
        chk("rd_T_stall", 32'(o_core_stall), 32'd1);
        step(); i_m0_req = 1'b0; #1;
        chk("rd_T1_en", 32'(o_mem_en), 32'd0);
        chk("rd_T1_rv0", 32'(o_m0_rvalid), 32'd0);
        chk("rd_T1_stall", 32'(o_core_stall), 32'd1);
        step(); i_mem_rdata = 32'hDEADBEEF; #1;
        chk("rd_T2_rv0", 32'(o_m0_rvalid), 32'd1);
        chk("rd_T2_rdata", o_m0_rdata, 32'hDEADBEEF);
        chk("rd_T2_rv1", 32'(o_m1_rvalid), 32'd0);
        chk("rd_T2_stall", 32'(o_core_stall), 32'd0);
        step(); i_mem_rdata = 32'h0; #1;
        chk("rd_T3_rv0", 32'(o_m0_rvalid), 32'd0);
        chk("rd_T3_hold", o_m0_rdata, 32'hDEADBEEF);

        // Port 1 read outstanding; port 0 store waits for the m1 rvalid cycle
        step(); i_m1_req = 1'b1; i_m1_we = 1'b0; i_m1_addr = 32'h200; #1;
        chk("m1rd_gnt1", 32'(o_m1_gnt), 32'd1);
        chk("m1rd_stall", 32'(o_core_stall), 32'd0);
        step(); i_m1_req = 1'b0;
        i_m0_req = 1'b1; i_m0_we = 1'b1; i_m0_addr = 32'h44; i_m0_wdata = 32'h55; #1;
        chk("m1rd_w_gnt0", 32'(o_m0_gnt), 32'd0);
        chk("m1rd_w_stall", 32'(o_core_stall), 32'd1);
        step(); i_mem_rdata = 32'h12345678; #1;
        chk("m1rd_rv1", 32'(o_m1_rvalid), 32'd1);
        chk("m1rd_rdata1", o_m1_rdata, 32'h12345678);
        chk("m1rd_rv0", 32'(o_m0_rvalid), 32'd0);
        chk("m1rd_gnt0", 32'(o_m0_gnt), 32'd1);
        chk("m1rd_addr", o_mem_addr, 32'h44);
        chk("m1rd_wdata", o_mem_wdata, 32'h55);
        chk("m1rd_stall_lo", 32'(o_core_stall), 32'd0);
        step(); i_m0_req = 1'b0; i_mem_rdata = 32'h0; #1;
        chk("m1rd_rv1_lo", 32'(o_m1_rvalid), 32'd0);
        chk("m1rd_hold1", o_m1_rdata, 32'h12345678);

        // Reset during RD_WAIT of a port 0 read
        step(); i_m0_req = 1'b1; i_m0_we = 1'b0; i_m0_addr = 32'h300; #1;
        chk("rrst_gnt0", 32'(o_m0_gnt), 32'd1);
        step(); i_m0_req = 1'b0; i_reset = 1'b0; #1;
        chk("rrst_rv0_a", 32'(o_m0_rvalid), 32'd0);
        chk("rrst_stall", 32'(o_core_stall), 32'd0);
        step(); i_reset = 1'b1; i_mem_rdata = 32'hBAD0BAD0; #1;
        chk("rrst_rv0_b", 32'(o_m0_rvalid), 32'd0);
        chk("rrst_rdata0", o_m0_rdata, 32'h0);
        step(); i_mem_rdata = 32'h0; #1;
        chk("rrst_rv0_c", 32'(o_m0_rvalid), 32'd0);
        step(); i_m0_req = 1'b1; i_m0_we = 1'b1; i_m0_addr = 32'h10;
        i_m1_req = 1'b1; i_m1_we = 1'b1; i_m1_addr = 32'h20; #1;
        chk("rrst_ptr_gnt0", 32'(o_m0_gnt), 32'd1);

        // Pointer now favours m1; m1 issues three writes with lock 1,1,0
`ifdef ARB_LOCK_EN
        step(); i_m1_lock = 1'b1; #1;
        chk("lk0_gnt1", 32'(o_m1_gnt), 32'd1);
        step(); i_m1_lock = 1'b1; #1;
        chk("lk1_gnt1", 32'(o_m1_gnt), 32'd1);
        chk("lk1_stall", 32'(o_core_stall), 32'd1);
        step(); i_m1_lock = 1'b0; #1;
        chk("lk2_gnt1", 32'(o_m1_gnt), 32'd1);
        chk("lk2_gnt0", 32'(o_m0_gnt), 32'd0);
        step(); i_m1_req = 1'b0; #1;
        chk("lk3_gnt0", 32'(o_m0_gnt), 32'd1);
`else
        step(); #1;
        chk("lk0_gnt1", 32'(o_m1_gnt), 32'd1);
        step(); #1;
        chk("lk1_gnt0", 32'(o_m0_gnt), 32'd1);
        chk("lk1_stall", 32'(o_core_stall), 32'd0);
        step(); #1;
        chk("lk2_gnt1", 32'(o_m1_gnt), 32'd1);
        chk("lk2_gnt0", 32'(o_m0_gnt), 32'd0);
        step(); i_m1_req = 1'b0; #1;
        chk("lk3_gnt0", 32'(o_m0_gnt), 32'd1);
`endif
        step(); i_m0_req = 1'b0; #1;
        chk("end_en", 32'(o_mem_en), 32'd0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
